// File: rtl/speck_key_expander_pkg.sv
// Shared definitions for the SPECK key-schedule engine: state encoding,
// per-configuration constants and width-generic rotate helpers.
package speck_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_EXPAND = 2'b01,
        ST_STREAM = 2'b10
    } state_t;

    // Rotation amounts: the 16-bit variant uses (7,2), all wider ones (8,3).
    function automatic int alpha_of(input int n);
        return (n == 32'sd16) ? 32'sd7 : 32'sd8;
    endfunction

    function automatic int beta_of(input int n);
        return (n == 32'sd16) ? 32'sd2 : 32'sd3;
    endfunction

    // Round count from the SPECK parameter table; 0 flags an illegal (n, m).
    function automatic int rounds_of(input int n, input int m);
        case (n)
            32'sd16: return (m == 32'sd4) ? 32'sd22 : 32'sd0;
            32'sd24: return (m == 32'sd3) ? 32'sd22 : (m == 32'sd4) ? 32'sd23 : 32'sd0;
            32'sd32: return (m == 32'sd3) ? 32'sd26 : (m == 32'sd4) ? 32'sd27 : 32'sd0;
            32'sd48: return (m == 32'sd2) ? 32'sd28 : (m == 32'sd3) ? 32'sd29 : 32'sd0;
            32'sd64: return (m == 32'sd2) ? 32'sd32 : (m == 32'sd3) ? 32'sd33 :
                            (m == 32'sd4) ? 32'sd34 : 32'sd0;
            default: return 32'sd0;
        endcase
    endfunction

    // Ones in the low n bits of a 64-bit container.
    function automatic logic [63:0] width_mask(input int n);
        return (n >= 32'sd64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
    endfunction

    // Rotate right by r within an n-bit word held in the low bits of x.
    function automatic logic [63:0] ror_w(input logic [63:0] x, input int r, input int n);
        return ((x >> r) | (x << (n - r))) & width_mask(n);
    endfunction

    // Rotate left by r within an n-bit word held in the low bits of x.
    function automatic logic [63:0] rol_w(input logic [63:0] x, input int r, input int n);
        return ((x << r) | (x >> (n - r))) & width_mask(n);
    endfunction

endpackage

// File: rtl/speck_key_expander_if.sv
// Round-key stream from the key expander to the round datapath.
interface speck_key_expander_if #(
    parameter int WORD_W = 64,
    parameter int IDX_W  = 5
);
    logic              rk_valid;
    logic              rk_ready;
    logic [WORD_W-1:0] rk_data;
    logic [IDX_W-1:0]  rk_index;

    modport master (output rk_valid, output rk_data, output rk_index, input rk_ready);
    modport slave  (input rk_valid, input rk_data, input rk_index, output rk_ready);
endinterface

// File: rtl/speck_ks_round.sv
// One SPECK key-schedule iteration (k, l0, i) -> (k_next, l_new).
// Purely combinational so the round-function datapath can reuse it.
module speck_ks_round
    import speck_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int IDX_W  = 5,
    parameter int ALPHA  = 8,
    parameter int BETA   = 3
) (
    input  logic [WORD_W-1:0] k,
    input  logic [WORD_W-1:0] l0,
    input  logic [IDX_W-1:0]  i,
    output logic [WORD_W-1:0] k_next,
    output logic [WORD_W-1:0] l_new
);
    logic [WORD_W-1:0] l0_ror_s;
    logic [WORD_W-1:0] k_rol_s;

    assign l0_ror_s = WORD_W'(ror_w(64'(l0), ALPHA, WORD_W));
    assign k_rol_s  = WORD_W'(rol_w(64'(k), BETA, WORD_W));
    // Addition wraps mod 2^WORD_W; the round counter is zero-extended.
    assign l_new    = (k + l0_ror_s) ^ WORD_W'(i);
    assign k_next   = k_rol_s ^ l_new;
endmodule

// File: rtl/speck_key_expander.sv
// SPECK key-schedule engine: latches a master key, expands it into a
// round-key buffer (one key per cycle), then streams the keys out.
// Optional macro SPECK_KS_DECRYPT_EN enables descending (decrypt) readout;
// without it, mode is ignored and readout is always ascending.
module speck_key_expander
    import speck_pkg::*;
#(
    parameter int WORD_W    = 64,
    parameter int KEY_WORDS = 2,
    parameter int ROUNDS    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        signal_start,
    input  logic                        mode,
    input  logic [KEY_WORDS*WORD_W-1:0] key,
    output logic                        busy,
    speck_key_expander_if.master        rk,
    output logic                        finished,
    output logic [1:0]                  state_response
);
    localparam int ALPHA = alpha_of(WORD_W);
    localparam int BETA  = beta_of(WORD_W);
    localparam int IDX_W = $clog2(ROUNDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);
    localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};

    state_t            state_r;
    logic [WORD_W-1:0] k_r;
    logic [WORD_W-1:0] l_r [KEY_WORDS-1];
    logic [IDX_W-1:0]  i_r;
    logic [IDX_W-1:0]  ptr_r;
    logic [IDX_W-1:0]  ptr_next_s;
    logic              last_key_s;
    logic [WORD_W-1:0] buffer_r [ROUNDS];
    logic              busy_r;
    logic              rk_valid_r;
    logic              finished_r;
    logic [WORD_W-1:0] rk_data_r;
    logic [IDX_W-1:0]  rk_index_r;
    logic [WORD_W-1:0] k_next_s;
    logic [WORD_W-1:0] l_new_s;
`ifdef SPECK_KS_DECRYPT_EN
    logic              mode_r;
`else
    logic              unused_mode_s;
    assign unused_mode_s = mode;
`endif

    speck_ks_round #(
        .WORD_W(WORD_W),
        .IDX_W (IDX_W),
        .ALPHA (ALPHA),
        .BETA  (BETA)
    ) u_round (
        .k     (k_r),
        .l0    (l_r[0]),
        .i     (i_r),
        .k_next(k_next_s),
        .l_new (l_new_s)
    );

    // Next read pointer and last-key detection for the latched readout order
    always_comb begin
        ptr_next_s = ptr_r + IDX_W'(1);
        last_key_s = (ptr_r == LAST_IDX);
`ifdef SPECK_KS_DECRYPT_EN
        if (mode_r) begin
            ptr_next_s = ptr_r - IDX_W'(1);
            last_key_s = (ptr_r == ZERO_IDX);
        end else begin
            ptr_next_s = ptr_r + IDX_W'(1);
            last_key_s = (ptr_r == LAST_IDX);
        end
`endif
    end

    // Round-key buffer write port; contents need no reset since an abort discards them
    always_ff @(posedge clk) begin
        if (state_r == ST_EXPAND) begin
            buffer_r[i_r] <= k_r;
        end
    end

    // Control FSM: key latch, expansion iterations and handshake-driven readout
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            k_r        <= {WORD_W{1'b0}};
            for (int j = 0; j < KEY_WORDS - 1; j++) begin
                l_r[j] <= {WORD_W{1'b0}};
            end
            i_r        <= ZERO_IDX;
            ptr_r      <= ZERO_IDX;
            busy_r     <= 1'b0;
            rk_valid_r <= 1'b0;
            finished_r <= 1'b0;
            rk_data_r  <= {WORD_W{1'b0}};
            rk_index_r <= ZERO_IDX;
`ifdef SPECK_KS_DECRYPT_EN
            mode_r     <= 1'b0;
`endif
        end else begin
            finished_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // A start coinciding with the finished pulse is dropped.
                    if (signal_start && !finished_r) begin
                        k_r <= key[WORD_W-1:0];
                        for (int j = 0; j < KEY_WORDS - 1; j++) begin
                            l_r[j] <= key[(j+1)*WORD_W +: WORD_W];
                        end
                        i_r     <= ZERO_IDX;
`ifdef SPECK_KS_DECRYPT_EN
                        mode_r  <= mode;
                        ptr_r   <= mode ? LAST_IDX : ZERO_IDX;
`else
                        ptr_r   <= ZERO_IDX;
`endif
                        busy_r  <= 1'b1;
                        state_r <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    // The final iteration only stores k; nothing further is needed.
                    if (i_r == LAST_IDX) begin
                        state_r <= ST_STREAM;
                    end else begin
                        k_r <= k_next_s;
                        for (int j = 0; j < KEY_WORDS - 2; j++) begin
                            l_r[j] <= l_r[j+1];
                        end
                        l_r[KEY_WORDS-2] <= l_new_s;
                        i_r <= i_r + IDX_W'(1);
                    end
                end
                ST_STREAM: begin
                    if (!rk_valid_r) begin
                        // First cycle of the stream: present the starting key.
                        rk_valid_r <= 1'b1;
                        rk_data_r  <= buffer_r[ptr_r];
                        rk_index_r <= ptr_r;
                    end else if (rk.rk_ready) begin
                        if (last_key_s) begin
                            rk_valid_r <= 1'b0;
                            finished_r <= 1'b1;
                            busy_r     <= 1'b0;
                            state_r    <= ST_IDLE;
                        end else begin
                            ptr_r      <= ptr_next_s;
                            rk_data_r  <= buffer_r[ptr_next_s];
                            rk_index_r <= ptr_next_s;
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    rk_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = busy_r;
    assign finished       = finished_r;
    assign state_response = state_r;
    assign rk.rk_valid    = rk_valid_r;
    assign rk.rk_data     = rk_data_r;
    assign rk.rk_index    = rk_index_r;
endmodule
